// File: rtl/h14tx_island_sched.sv
// h14tx_island_sched: data-island scheduler between the raster timing
// generator and the channel encoders. It inserts one HDMI data island per
// line into the horizontal Control run. The island starts at IslandStart and
// is laid out as 8 preamble characters, 2 leading guard characters,
// N x 32 packet characters and 2 trailing guard characters.
//
// Ports:
//   clk, rst_n       character clock, asynchronous active-low reset
//   x_i              horizontal position of the incoming character
//   hsync_i/vsync_i  syncs from the timing generator
//   period_i         incoming period (Control / Video*)
//   en               island enable, sampled only at the island start
//   pkt_valid        packet source has a packet ready
//   pkt_ready        pulse on the last character of each packet sent
//   pkt_idx          character index 0..31 within the current packet
//   pkt_first        high on character 0 of each packet
//   period_o         period_i, or Data* during an island
//   hsync_o/vsync_o  syncs delayed by 1 cycle
//   abort            pulse when an island is cut short by a non-Control period
// Every output is registered and describes the input character of the
// previous cycle.

package h14tx_island_sched_pkg;
  typedef enum logic [2:0] {
    CONTROL        = 3'd0,
    VIDEO_ACTIVE   = 3'd1,
    VIDEO_PREAMBLE = 3'd2,
    VIDEO_GUARD    = 3'd3,
    DATA_PREAMBLE  = 3'd4,
    DATA_GUARD     = 3'd5,
    DATA_ACTIVE    = 3'd6
  } period_t;
endpackage

module h14tx_island_sched
  import h14tx_island_sched_pkg::*;
#(
  parameter int BitWidth       = 11,
  parameter int FrameWidth     = 1650,
  parameter int IslandStart    = 1292,
  parameter int IslandDeadline = 1628,
  parameter int MaxPackets     = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BitWidth-1:0] x_i,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  period_t             period_i,
  input  logic                en,
  input  logic                pkt_valid,
  output logic                pkt_ready,
  output logic [4:0]          pkt_idx,
  output logic                pkt_first,
  output period_t             period_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                abort
);

  if (!((IslandStart + 44 <= IslandDeadline) && (IslandDeadline < FrameWidth))) begin : g_cfg_check
    $fatal(1, "h14tx_island_sched: island window does not fit the line");
  end

  localparam int CntW = $clog2(MaxPackets + 1);
  localparam logic [BitWidth-1:0] StartX    = BitWidth'(IslandStart);
  localparam logic [BitWidth:0]   DeadlineX = (BitWidth + 1)'(IslandDeadline);
  // One more packet (32) plus the trailing guard (2), measured from the
  // current character, must finish strictly before the deadline.
  localparam logic [BitWidth:0]   TailLen   = (BitWidth + 1)'(35);
  localparam logic [CntW-1:0]     MaxCnt    = CntW'(MaxPackets);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_GL, S_DATA, S_GT} state_t;

  state_t          state_q, state_d;
  logic [4:0]      char_cnt_q, char_cnt_d;
  logic [CntW-1:0] pkt_cnt_q, pkt_cnt_d;
  period_t         period_d;
  logic [4:0]      idx_d;
  logic            ready_d, first_d, abort_d;
  logic            start_ok, tail_fits;

  assign start_ok  = (x_i == StartX) && (period_i == CONTROL) && en && pkt_valid;
  assign tail_fits = ({1'b0, x_i} + TailLen) <= DeadlineX;

  always_comb begin
    state_d    = state_q;
    char_cnt_d = char_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    period_d   = period_i;
    idx_d      = pkt_idx;
    ready_d    = 1'b0;
    first_d    = 1'b0;
    abort_d    = 1'b0;

    if (state_q == S_IDLE) begin
      // The start character itself is the first preamble character.
      if (start_ok) begin
        state_d    = S_PRE;
        char_cnt_d = 5'd1;
        period_d   = DATA_PREAMBLE;
      end
    end else if (period_i != CONTROL) begin
      // Timing violation: drop the island, pass the input period through.
      state_d    = S_IDLE;
      char_cnt_d = '0;
      pkt_cnt_d  = '0;
      abort_d    = 1'b1;
    end else begin
      case (state_q)
        S_PRE: begin
          period_d = DATA_PREAMBLE;
          if (char_cnt_q == 5'd7) begin
            state_d    = S_GL;
            char_cnt_d = '0;
          end else begin
            char_cnt_d = char_cnt_q + 5'd1;
          end
        end
        S_GL: begin
          period_d = DATA_GUARD;
          if (char_cnt_q == 5'd1) begin
            state_d    = S_DATA;
            char_cnt_d = '0;
            pkt_cnt_d  = CntW'(1);
          end else begin
            char_cnt_d = char_cnt_q + 5'd1;
          end
        end
        S_DATA: begin
          period_d   = DATA_ACTIVE;
          idx_d      = char_cnt_q;
          first_d    = (char_cnt_q == 5'd0);
          char_cnt_d = char_cnt_q + 5'd1;
          if (char_cnt_q == 5'd31) begin
            ready_d    = 1'b1;
            char_cnt_d = '0;
            if (pkt_valid && (pkt_cnt_q < MaxCnt) && tail_fits) begin
              pkt_cnt_d = pkt_cnt_q + CntW'(1);
            end else begin
              state_d = S_GT;
            end
          end
        end
        S_GT: begin
          period_d = DATA_GUARD;
          if (char_cnt_q == 5'd1) begin
            state_d    = S_IDLE;
            char_cnt_d = '0;
            pkt_cnt_d  = '0;
          end else begin
            char_cnt_d = char_cnt_q + 5'd1;
          end
        end
        default: begin
          state_d    = S_IDLE;
          char_cnt_d = '0;
          pkt_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      char_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      period_o   <= CONTROL;
      hsync_o    <= 1'b0;
      vsync_o    <= 1'b0;
      pkt_ready  <= 1'b0;
      pkt_first  <= 1'b0;
      pkt_idx    <= '0;
      abort      <= 1'b0;
    end else begin
      state_q    <= state_d;
      char_cnt_q <= char_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      period_o   <= period_d;
      hsync_o    <= hsync_i;
      vsync_o    <= vsync_i;
      pkt_ready  <= ready_d;
      pkt_first  <= first_d;
      pkt_idx    <= idx_d;
      abort      <= abort_d;
    end
  end

endmodule

// File: tb/tb_h14tx_island_sched.sv
// Testbench for h14tx_island_sched. Two instances share the stimulus: one
// with the default MaxPackets=18 and one with MaxPackets=2. A position-based
// reference model predicts every output each cycle; directed lines are
// checked against a table of expected island layouts.
module tb_h14tx_island_sched;
  import h14tx_island_sched_pkg::*;

  localparam int Start = 1292;
  localparam int Dead  = 1628;
  localparam int Width = 1650;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x_i;
  logic        hsync_i, vsync_i, en, pkt_valid;
  period_t     period_i;

  period_t     per_o [2];
  logic        rdy_o [2];
  logic        first_o [2];
  logic        ab_o [2];
  logic        hs_o [2];
  logic        vs_o [2];
  logic [4:0]  idx_o [2];

  always #5 clk = ~clk;

  h14tx_island_sched dut (
    .clk(clk), .rst_n(rst_n), .x_i(x_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .period_i(period_i), .en(en), .pkt_valid(pkt_valid),
    .pkt_ready(rdy_o[0]), .pkt_idx(idx_o[0]), .pkt_first(first_o[0]),
    .period_o(per_o[0]), .hsync_o(hs_o[0]), .vsync_o(vs_o[0]), .abort(ab_o[0])
  );

  h14tx_island_sched #(.MaxPackets(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .x_i(x_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .period_i(period_i), .en(en), .pkt_valid(pkt_valid),
    .pkt_ready(rdy_o[1]), .pkt_idx(idx_o[1]), .pkt_first(first_o[1]),
    .period_o(per_o[1]), .hsync_o(hs_o[1]), .vsync_o(vs_o[1]), .abort(ab_o[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         maxp [2] = '{18, 2};
  int         m_pos [2];   // index of the current character within the island, -1 if none
  int         m_npk [2];   // packets committed to this island so far
  period_t    exp_per [2];
  logic       exp_rdy [2], exp_first [2], exp_ab [2];
  logic [4:0] exp_idx [2];
  logic       exp_h, exp_v;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = -1; m_npk[k] = 0; exp_idx[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    int p, data_end, ci;
    exp_rdy[k] = 1'b0; exp_first[k] = 1'b0; exp_ab[k] = 1'b0;
    exp_per[k] = period_i;
    if (m_pos[k] < 0) begin
      if (int'(x_i) == Start && period_i == CONTROL && en && pkt_valid) begin
        m_pos[k] = 0; m_npk[k] = 1; exp_per[k] = DATA_PREAMBLE;
      end
    end else if (period_i != CONTROL) begin
      exp_ab[k] = 1'b1; m_pos[k] = -1;
    end else begin
      p = m_pos[k] + 1;
      m_pos[k] = p;
      data_end = 10 + 32 * m_npk[k];
      if (p < 8) exp_per[k] = DATA_PREAMBLE;
      else if (p < 10) exp_per[k] = DATA_GUARD;
      else if (p < data_end) begin
        ci = (p - 10) % 32;
        exp_per[k] = DATA_ACTIVE;
        exp_idx[k] = 5'(ci);
        exp_first[k] = (ci == 0);
        if (ci == 31) begin
          exp_rdy[k] = 1'b1;
          if (pkt_valid && m_npk[k] < maxp[k] && int'(x_i) + 35 <= Dead) m_npk[k]++;
        end
      end else begin
        exp_per[k] = DATA_GUARD;
        if (p == data_end + 1) m_pos[k] = -1;
      end
    end
  endtask

  // ---------------- observation ----------------
  int obs_pre [2], obs_first [2], obs_rdy [2], obs_last [2], obs_ab [2];
  int seg_len [2], seg32 [2], tot_rdy [2], viol [2];

  function automatic logic [12:0] pack(period_t p, logic h, logic v, logic r, logic f,
                                       logic [4:0] i, logic a);
    return {p, h, v, r, f, i, a};
  endfunction

  task automatic clear_obs();
    for (int k = 0; k < 2; k++) begin
      obs_pre[k] = -1; obs_first[k] = -1; obs_rdy[k] = 0; obs_last[k] = -1; obs_ab[k] = 0;
    end
  endtask

  task automatic check_outputs(input int x);
    bit is_data;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out%0d_x%0d", k, x),
          pack(per_o[k], hs_o[k], vs_o[k], rdy_o[k], first_o[k], idx_o[k], ab_o[k]),
          pack(exp_per[k], exp_h, exp_v, exp_rdy[k], exp_first[k], exp_idx[k], exp_ab[k]));
      is_data = per_o[k] inside {DATA_PREAMBLE, DATA_GUARD, DATA_ACTIVE};
      if (per_o[k] == DATA_PREAMBLE && obs_pre[k] < 0) obs_pre[k] = x;
      if (first_o[k] && obs_first[k] < 0) obs_first[k] = x;
      if (is_data) obs_last[k] = x;
      if (is_data && x >= Dead) viol[k]++;
      if (rdy_o[k]) begin obs_rdy[k]++; tot_rdy[k]++; end
      if (ab_o[k]) obs_ab[k]++;
      if (per_o[k] == DATA_ACTIVE) begin
        if (first_o[k]) begin
          if (seg_len[k] == 32) seg32[k]++;
          seg_len[k] = 1;
        end else if (seg_len[k] > 0) seg_len[k]++;
      end else begin
        if (seg_len[k] == 32) seg32[k]++;
        seg_len[k] = 0;
      end
    end
  endtask

  task automatic cyc(input int x, input logic h, input logic v, input period_t per,
                     input logic e, input logic val);
    x_i = 11'(x); hsync_i = h; vsync_i = v; period_i = per; en = e; pkt_valid = val;
    exp_h = h; exp_v = v;
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    check_outputs(x);
  endtask

  task automatic do_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_async_period%0d", k), per_o[k], CONTROL);
      chk($sformatf("rst_async_ready%0d", k), rdy_o[k], 0);
    end
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  // One full line. abort_x / rst_x of -1 disable the respective event.
  task automatic run_line(input logic e_start, input logic v_start, input int v_until,
                          input int abort_x, input int rst_x, input logic active,
                          input logic vs, input logic rnd);
    period_t per;
    logic    e, val, e_line;
    clear_obs();
    e_line = ($urandom_range(0, 7) != 0);
    for (int x = 0; x < Width; x++) begin
      per = CONTROL;
      if (active && x < 1280) per = VIDEO_ACTIVE;
      if (x >= 1640 && x < 1648) per = VIDEO_PREAMBLE;
      if (x >= 1648) per = VIDEO_GUARD;
      if (x == abort_x) per = VIDEO_PREAMBLE;
      if (rnd) begin
        e = e_line;
        val = ($urandom_range(0, 3) != 0);
      end else begin
        e = (x == Start) ? e_start : 1'b1;
        val = (x == Start) ? v_start : (x <= v_until);
      end
      cyc(x, (x >= 1390 && x < 1430), vs, per, e, val);
      if (x == abort_x) begin
        chk("abort_period_next", per_o[0], VIDEO_PREAMBLE);
        chk("abort_pulse", ab_o[0], 1);
      end
      if (x == rst_x) do_reset_mid();
    end
  endtask

  typedef struct {
    logic e_start;
    logic v_start;
    int   v_until;
    int   pre_x;
    int   first_x;
    int   rdy_a;
    int   last_a;
    int   rdy_b;
    int   last_b;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1332, 1292, 1302, 1, 1335, 1, 1335};   // single packet
    vecs[1] = '{1'b1, 1'b1, 4000, 1292, 1302, 10, 1623, 2, 1367};  // valid held
    vecs[2] = '{1'b1, 1'b0, 4000, -1, -1, 0, -1, 0, -1};           // no valid at start
    vecs[3] = '{1'b0, 1'b1, 4000, -1, -1, 0, -1, 0, -1};           // disabled

    rst_n = 1'b0; x_i = '0; hsync_i = 1'b0; vsync_i = 1'b0; period_i = CONTROL;
    en = 1'b0; pkt_valid = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      seg_len[k] = 0; seg32[k] = 0; tot_rdy[k] = 0; viol[k] = 0;
      exp_per[k] = CONTROL;
    end
    #12;
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_state%0d", k),
          pack(per_o[k], hs_o[k], vs_o[k], rdy_o[k], first_o[k], idx_o[k], ab_o[k]),
          pack(CONTROL, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0));
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_line(vecs[i].e_start, vecs[i].v_start, vecs[i].v_until, -1, -1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_pre_x", i), obs_pre[0], vecs[i].pre_x);
      chk($sformatf("v%0d_first_x", i), obs_first[0], vecs[i].first_x);
      chk($sformatf("v%0d_ready_a", i), obs_rdy[0], vecs[i].rdy_a);
      chk($sformatf("v%0d_last_a", i), obs_last[0], vecs[i].last_a);
      chk($sformatf("v%0d_ready_b", i), obs_rdy[1], vecs[i].rdy_b);
      chk($sformatf("v%0d_last_b", i), obs_last[1], vecs[i].last_b);
    end

    // Reset while pkt_idx is 10, then a clean island on the next line.
    run_line(1'b1, 1'b1, 4000, -1, 1312, 1'b0, 1'b0, 1'b0);
    chk("rst_line_last", obs_last[0], 1312);
    chk("rst_line_ready", obs_rdy[0], 0);
    run_line(1'b1, 1'b1, 4000, -1, -1, 1'b0, 1'b0, 1'b0);
    chk("after_rst_pre_x", obs_pre[0], 1292);
    chk("after_rst_ready", obs_rdy[0], 10);

    // Non-Control period forced into the packet region.
    run_line(1'b1, 1'b1, 4000, 1310, -1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort_count%0d", k), obs_ab[k], 1);
      chk($sformatf("abort_ready%0d", k), obs_rdy[k], 0);
      chk($sformatf("abort_last%0d", k), obs_last[k], 1309);
    end

    // Three small frames of five lines with random pkt_valid and en.
    for (int k = 0; k < 2; k++) begin
      seg_len[k] = 0; seg32[k] = 0; tot_rdy[k] = 0; viol[k] = 0;
    end
    for (int ln = 0; ln < 15; ln++)
      run_line(1'b1, 1'b1, 4000, -1, -1, (ln % 5) >= 2, (ln % 5) == 0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("long_ready_vs_runs%0d", k), tot_rdy[k], seg32[k]);
      chk($sformatf("long_late_island%0d", k), viol[k], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
